mem_responder: RTL

Responder end of the core's memory valid/ack interface: a single-port word-organised RAM that accepts one request at a time from an initiator (core imem or dmem port), waits a configurable number of cycles, then completes the access with a one-cycle ack. It sits between the barebones core and simulation/FPGA memory and provides a reusable, latency-configurable target for testbenches and small SoCs.

---
 rtl/mem_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-request memory target for the core's valid/ack bus.
// Accepts one request, waits LATENCY cycles from acceptance, performs the
// word/byte-lane access and strobes ack for one cycle.
module mem_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          LATENCY    = 1,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [3:0]  mem_sel_i,
  input  logic        mem_we_i,
  input  logic        mem_valid_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t state_reg, state_next;
  logic [3:0] count_reg, count_next;
  logic       capture;

  // Captured request fields (byte offset bits are never needed).
  logic [31:2] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  sel_reg;
  logic        we_reg;

  logic [31:0] rdata_reg;

  // Fields actually used for the access on the edge that enters ACK.
  logic [31:2]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_sel;
  logic                  acc_we;
  logic                  acc_in_range;
  logic [ADDR_WIDTH-1:0] acc_index;
  logic                  access_en;

  logic unused_addr_bits;

  logic [31:0] ram [DEPTH];

  assign unused_addr_bits = ^mem_addr_i[1:0];

  // Next-state logic. The counter holds the number of WAIT edges still to
  // go including the one that moves to ACK, so it reaches ACK on the edge
  // LATENCY-1 after acceptance and never goes below zero.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_valid_i) begin
          capture    = 1'b1;
          count_next = 4'(LATENCY - 1);
          state_next = (LATENCY == 1) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!mem_valid_i) begin
          state_next = IDLE;
          count_next = 4'd0;
        end else if (count_reg <= 4'd1) begin
          state_next = ACK;
          count_next = 4'd0;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = 4'd0;
      end
    endcase
  end

  // Access source: live inputs when going straight from IDLE to ACK,
  // otherwise the fields captured at acceptance.
  always_comb begin
    if (state_reg == IDLE) begin
      acc_addr  = mem_addr_i[31:2];
      acc_wdata = mem_data_i;
      acc_sel   = mem_sel_i;
      acc_we    = mem_we_i;
    end else begin
      acc_addr  = addr_reg;
      acc_wdata = wdata_reg;
      acc_sel   = sel_reg;
      acc_we    = we_reg;
    end
  end

  assign acc_in_range = (acc_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign acc_index    = acc_addr[ADDR_WIDTH+1:2];
  // Reset held high must never let a request reach memory.
  assign access_en    = (state_next == ACK) && (state_reg != ACK) && !rst_i;

  // Control, capture and read-data registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
      addr_reg  <= '0;
      wdata_reg <= 32'h0;
      sel_reg   <= 4'h0;
      we_reg    <= 1'b0;
      rdata_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (capture) begin
        addr_reg  <= mem_addr_i[31:2];
        wdata_reg <= mem_data_i;
        sel_reg   <= mem_sel_i;
        we_reg    <= mem_we_i;
      end
      if (access_en && !acc_we) begin
        rdata_reg <= acc_in_range ? ram[acc_index] : 32'h0;
      end
    end
  end

  // Byte-lane write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (access_en && acc_we && acc_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_sel[b]) begin
          ram[acc_index][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  assign mem_ack_o  = (state_reg == ACK);
  assign mem_data_o = rdata_reg;

endmodule
